mem_request_queue: RTL and testbench
====================================

# mem_request_queue

Request buffer downstream of `parser`: captures each parsed memory request (`opcode`, `address`) on the cycle `op_ready_s` is asserted and holds up to `DEPTH` requests in arrival order for the DRAM command scheduler. It exposes the oldest request with a per-entry age count for scheduling timing checks, and raises `queue_full` as back-pressure so the parser stalls trace consumption.

## Interface
- `ADDRESS_WIDTH`, default 32: request address width; matches parser.
- `DEPTH`, default 16: queue entries; power of two, at least 2.
- `AGE_WIDTH`, default 8: width of per-entry age counter.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  one clock domain; reset is synchronous and active-high.
- `op_ready_s`  in  1  parser strobe; one-cycle pulse per valid request.
- `opcode`  in  `parsed_op_t`  request type from parser (0 data read, 1 data write, 2 instruction fetch).
- `address`  in  ADDRESS_WIDTH  request address from parser.
- `pop`  in  1  scheduler retires the head entry this cycle.
- `queue_full`  out  1  occupancy == DEPTH; parser must not strobe.
- `queue_empty`  out  1  occupancy == 0.
- `head_valid`  out  1  head entry present (== !queue_empty).
- `head_opcode`  out  `parsed_op_t`  opcode of oldest entry.
- `head_address`  out  ADDRESS_WIDTH  address of oldest entry.
- `head_age`  out  AGE_WIDTH  cycles the oldest entry has been queued.
- `occupancy`  out  $clog2(DEPTH)+1  entries held, 0..DEPTH.
- `overflow_err`  out  1  sticky; a strobe arrived while full.

## Operation
- Circular buffer of `DEPTH` entries; write pointer and read pointer, each $clog2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0; separate occupancy counter.
- Push condition: `op_ready_s && !queue_full`. Stores `{opcode, address}` at write pointer, clears that entry's age to 0, and advances the write pointer.
- Pop condition: `pop && head_valid`. Advances the read pointer. `pop` while empty is ignored; no error is flagged.
- Simultaneous push and pop:
  - Non-empty, non-full: both occur; occupancy unchanged.
  - Empty: push only, because the pop is ignored.
  - Full: pop only. The push is dropped and `overflow_err` is set; full status is evaluated before the edge, with no same-cycle bypass.
- `op_ready_s` while full: request is discarded, storage is untouched, and `overflow_err` is set to 1 until reset.
- Age: each valid entry's counter increments by 1 every cycle after the one in which it was written, and saturates at 2^AGE_WIDTH−1. Invalid entries hold their value.
- Head outputs are driven combinationally from the entry at the read pointer. When empty, `head_opcode`, `head_address` and `head_age` are 0.
- `occupancy` changes by +1, −1 or 0 per cycle only; it never exceeds DEPTH and never goes negative.

## Timing
- Reset (synchronous, `rst` high at rising edge):
  - Pointers, occupancy, all ages and `overflow_err` are cleared.
  - Outputs: `queue_empty`=1, `head_valid`=0, `queue_full`=0, `occupancy`=0, head fields=0.
  - Reset mid-operation discards all entries. A strobe on the reset cycle is dropped.
- Latency: request strobed at edge N is visible on head outputs (if the queue was empty) from edge N, i.e. during cycle N+1, with `head_age`=0. It reads 1 after edge N+1.
- `pop` sampled at edge N: the next entry, or empty status, is visible after edge N.
- `queue_full` and `queue_empty` are registered-state derived. They update in the cycle after the push or pop that changes them.
- Throughput: one push and one pop per cycle sustained.

## Structure
- `global_defs`:
  - Holds `parsed_op_t` (existing).
  - New `queue_entry_t` struct: `{parsed_op_t opcode; logic [ADDRESS_WIDTH-1:0] address;}`.
  - New constant `QUEUE_DEPTH = 16`, used as the default.
- Single module; the entry array plus an age array of `AGE_WIDTH`-bit counters. No sub-module is needed.
- Top-level connects `parser.op_ready_s/opcode/address` directly. The parser holds its trace line while `queue_full` is high.

## Test plan
- Reset, then strobe write to `0x0000_1A40`: next cycle `head_valid`=1, `head_opcode`=1, `head_address`=`0x0000_1A40`, `occupancy`=1, `head_age`=0. Ten idle cycles later, `head_age`=10.
- Push 16 requests with addresses 0x10..0x1F: `queue_full`=1 after the 16th. A 17th strobe leaves `occupancy`=16 and sets `overflow_err`=1. Pop 16 times: head addresses come out 0x10..0x1F in order, then `queue_empty`=1.
- Wrap-around: push 12, pop 12, push 8: head address equals the first of the 8, ordering is preserved, and `occupancy`=8.
- Simultaneous push and pop at `occupancy`=5: occupancy stays 5. Pop while empty: no change, `overflow_err` stays 0.
- Age saturation: hold one entry 300 cycles with AGE_WIDTH=8: `head_age`=255.
- Reset mid-queue with 7 entries: next cycle `occupancy`=0, `head_valid`=0, `overflow_err`=0.

Source files
------------

// File: rtl/mem_request_queue_pkg.sv
// Shared request types for the parser-to-scheduler path and the queue's default sizing.
package mem_request_queue_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2
  } parsed_op_t;

  localparam int QUEUE_DEPTH           = 16;
  localparam int DEFAULT_ADDRESS_WIDTH = 32;
  localparam int DEFAULT_AGE_WIDTH     = 8;

endpackage

// File: rtl/mem_request_queue.sv
// In-order request buffer between the trace parser and the DRAM command scheduler,
// exposing the oldest request together with how long it has been waiting.
module mem_request_queue
  import mem_request_queue_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DEPTH         = QUEUE_DEPTH,
  parameter int AGE_WIDTH     = DEFAULT_AGE_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       op_ready_s,
  input  parsed_op_t                 opcode,
  input  logic [ADDRESS_WIDTH-1:0]   address,
  input  logic                       pop,
  output logic                       queue_full,
  output logic                       queue_empty,
  output logic                       head_valid,
  output parsed_op_t                 head_opcode,
  output logic [ADDRESS_WIDTH-1:0]   head_address,
  output logic [AGE_WIDTH-1:0]       head_age,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    parsed_op_t                opcode;
    logic [ADDRESS_WIDTH-1:0]  address;
  } queue_entry_t;

  queue_entry_t          entries_q [DEPTH];
  logic [AGE_WIDTH-1:0]  age_q     [DEPTH];
  logic [AGE_WIDTH-1:0]  age_d     [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q,  count_d;
  logic                  overflow_q, overflow_d;
  logic [DEPTH-1:0]      entry_valid;
  logic                  push_en, pop_en;

  // Full/empty come straight from registered occupancy, so a pop never frees room for a same-cycle push.
  assign queue_full  = (count_q == CNT_W'(DEPTH));
  assign queue_empty = (count_q == '0);
  assign head_valid  = !queue_empty;
  assign push_en     = op_ready_s && !queue_full;
  assign pop_en      = pop && head_valid;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (op_ready_s && queue_full);
    if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // An entry is live when its distance ahead of the read pointer is below the occupancy.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] offset;
      offset         = PTR_W'(i) - rd_ptr_q;
      entry_valid[i] = ({1'b0, offset} < count_q);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_d[i] = age_q[i];
      if (entry_valid[i] && (age_q[i] != '1)) age_d[i] = age_q[i] + AGE_WIDTH'(1);
      if (push_en && (wr_ptr_q == PTR_W'(i))) age_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      entries_q[wr_ptr_q].opcode  <= opcode;
      entries_q[wr_ptr_q].address <= address;
    end
  end

  always_comb begin
    head_opcode  = OP_READ;
    head_address = '0;
    head_age     = '0;
    if (head_valid) begin
      head_opcode  = entries_q[rd_ptr_q].opcode;
      head_address = entries_q[rd_ptr_q].address;
      head_age     = age_q[rd_ptr_q];
    end
  end

  assign occupancy    = count_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_mem_request_queue.sv
// Scenario-driven bench for mem_request_queue with a FIFO scoreboard of expected head entries.
module tb_mem_request_queue;
  import mem_request_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 32;
  localparam int AGEW  = 8;
  localparam int AGE_MAX = (1 << AGEW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            op_ready_s = 1'b0;
  parsed_op_t      opcode = OP_READ;
  logic [AW-1:0]   address = '0;
  logic            pop = 1'b0;
  logic            queue_full, queue_empty, head_valid, overflow_err;
  parsed_op_t      head_opcode;
  logic [AW-1:0]   head_address;
  logic [AGEW-1:0] head_age;
  logic [4:0]      occupancy;

  typedef struct {
    parsed_op_t    op;
    logic [AW-1:0] addr;
    int unsigned   t;
  } sb_t;

  sb_t         sb[$];
  int unsigned cyc = 0;
  logic        exp_ovf = 1'b0;
  int          checks = 0;
  int          errors = 0;

  mem_request_queue #(.ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .AGE_WIDTH(AGEW)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_ready_s   (op_ready_s),
    .opcode       (opcode),
    .address      (address),
    .pop          (pop),
    .queue_full   (queue_full),
    .queue_empty  (queue_empty),
    .head_valid   (head_valid),
    .head_opcode  (head_opcode),
    .head_address (head_address),
    .head_age     (head_age),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One clock with optional strobe and pop; the model decides full/empty from pre-edge state.
  task automatic drive_cycle(input logic do_push, input parsed_op_t op, input logic [AW-1:0] a,
                             input logic do_pop);
    bit  push_ok, pop_ok;
    sb_t e;
    push_ok = do_push && (sb.size() < DEPTH);
    pop_ok  = do_pop && (sb.size() > 0);
    if (do_push && !push_ok) exp_ovf = 1'b1;
    op_ready_s = do_push;
    opcode     = op;
    address    = a;
    pop        = do_pop;
    step();
    op_ready_s = 1'b0;
    pop        = 1'b0;
    if (pop_ok) sb.delete(0);
    if (push_ok) begin
      e.op   = op;
      e.addr = a;
      e.t    = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, OP_READ, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_ready_s = 1'b0;
    pop = 1'b0;
    step();
    rst = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
  endtask

  function automatic logic [AGEW-1:0] model_age(input int unsigned t);
    int unsigned d;
    d = cyc - t;
    return (d > AGE_MAX) ? AGEW'(AGE_MAX) : AGEW'(d);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    op_ready_s = 1'b1;
    address = 32'hDEAD_0000;
    step();
    rst = 1'b0;
    op_ready_s = 1'b0;
    sb.delete();
    exp_ovf = 1'b0;
    checks++;
    if (queue_empty !== 1'b1 || head_valid !== 1'b0 || queue_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: empty=%b valid=%b full=%b, required 1 0 0",
               queue_empty, head_valid, queue_full);
    end
    checks++;
    if (occupancy !== 5'd0 || overflow_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_counts: occ=%0d ovf=%b, required 0 0", occupancy, overflow_err);
    end
    checks++;
    if (head_address !== '0 || head_opcode !== OP_READ || head_age !== '0) begin
      errors++;
      $display("[TB] FAIL reset_head: addr=%h op=%0d age=%0d, required zeros",
               head_address, head_opcode, head_age);
    end
  endtask

  task automatic test_single_push_age();
    do_reset();
    drive_cycle(1'b1, OP_WRITE, 32'h0000_1A40, 1'b0);
    checks++;
    if (head_valid !== 1'b1 || head_opcode !== OP_WRITE || head_address !== 32'h0000_1A40) begin
      errors++;
      $display("[TB] FAIL single_head: valid=%b op=%0d addr=%h, required 1 1 00001a40",
               head_valid, head_opcode, head_address);
    end
    checks++;
    if (occupancy !== 5'd1 || head_age !== 8'd0 || queue_empty !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_state: occ=%0d age=%0d empty=%b, required 1 0 0",
               occupancy, head_age, queue_empty);
    end
    idle(1);
    checks++;
    if (head_age !== 8'd1) begin
      errors++;
      $display("[TB] FAIL age_one: got %0d, required 1", head_age);
    end
    idle(9);
    checks++;
    if (head_age !== 8'd10) begin
      errors++;
      $display("[TB] FAIL age_ten: got %0d, required 10", head_age);
    end
  endtask

  // Pops everything in the model, checking each head against the scoreboard front first.
  task automatic drain(input string tag);
    while (sb.size() > 0) begin
      checks++;
      if (head_valid !== 1'b1 || head_address !== sb[0].addr || head_opcode !== sb[0].op
          || head_age !== model_age(sb[0].t)) begin
        errors++;
        $display("[TB] FAIL %s_head: valid=%b addr=%h op=%0d age=%0d, required 1 %h %0d %0d",
                 tag, head_valid, head_address, head_opcode, head_age,
                 sb[0].addr, sb[0].op, model_age(sb[0].t));
      end
      checks++;
      if (occupancy !== 5'(sb.size()) || queue_full !== (sb.size() == DEPTH)) begin
        errors++;
        $display("[TB] FAIL %s_occ: occ=%0d full=%b, required %0d %b",
                 tag, occupancy, queue_full, sb.size(), sb.size() == DEPTH);
      end
      drive_cycle(1'b0, OP_READ, '0, 1'b1);
    end
    checks++;
    if (queue_empty !== 1'b1 || head_valid !== 1'b0 || occupancy !== 5'd0) begin
      errors++;
      $display("[TB] FAIL %s_empty: empty=%b valid=%b occ=%0d, required 1 0 0",
               tag, queue_empty, head_valid, occupancy);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      drive_cycle(1'b1, parsed_op_t'(2'(i % 3)), AW'(32'h10 + i), 1'b0);
    checks++;
    if (queue_full !== 1'b1 || occupancy !== 5'd16 || overflow_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fill_full: full=%b occ=%0d ovf=%b, required 1 16 0",
               queue_full, occupancy, overflow_err);
    end
    drive_cycle(1'b1, OP_IFETCH, 32'hBAD0_0000, 1'b0);
    checks++;
    if (occupancy !== 5'd16 || overflow_err !== exp_ovf || head_address !== 32'h10) begin
      errors++;
      $display("[TB] FAIL overflow: occ=%0d ovf=%b head=%h, required 16 1 00000010",
               occupancy, overflow_err, head_address);
    end
    drain("fill");
    checks++;
    if (overflow_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_sticky: got %b, required 1", overflow_err);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, OP_READ, AW'(32'h100 + i), 1'b0);
    for (int i = 0; i < 12; i++) drive_cycle(1'b0, OP_READ, '0, 1'b1);
    for (int i = 0; i < 8; i++)
      drive_cycle(1'b1, parsed_op_t'(2'((i + 1) % 3)), AW'(32'h200 + i), 1'b0);
    checks++;
    if (head_address !== 32'h200 || occupancy !== 5'd8) begin
      errors++;
      $display("[TB] FAIL wrap_head: addr=%h occ=%0d, required 00000200 8", head_address, occupancy);
    end
    drain("wrap");
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_cycle(1'b0, OP_READ, '0, 1'b1);
    checks++;
    if (occupancy !== 5'd0 || overflow_err !== 1'b0 || queue_empty !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_pop: occ=%0d ovf=%b empty=%b, required 0 0 1",
               occupancy, overflow_err, queue_empty);
    end
    drive_cycle(1'b1, OP_WRITE, 32'h300, 1'b1);
    checks++;
    if (occupancy !== 5'd1 || head_address !== 32'h300) begin
      errors++;
      $display("[TB] FAIL empty_pushpop: occ=%0d addr=%h, required 1 00000300", occupancy, head_address);
    end
    for (int i = 1; i < 5; i++) drive_cycle(1'b1, OP_READ, AW'(32'h300 + i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, OP_IFETCH, AW'(32'h400 + i), 1'b1);
      checks++;
      if (occupancy !== 5'd5 || head_address !== sb[0].addr) begin
        errors++;
        $display("[TB] FAIL pushpop_%0d: occ=%0d addr=%h, required 5 %h",
                 i, occupancy, head_address, sb[0].addr);
      end
    end
    while (sb.size() < DEPTH) drive_cycle(1'b1, OP_WRITE, AW'(32'h500 + sb.size()), 1'b0);
    drive_cycle(1'b1, OP_READ, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if (occupancy !== 5'd15 || overflow_err !== 1'b1 || queue_full !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_pushpop: occ=%0d ovf=%b full=%b, required 15 1 0",
               occupancy, overflow_err, queue_full);
    end
    drain("b2b");
  endtask

  task automatic test_age_saturation();
    do_reset();
    drive_cycle(1'b1, OP_READ, 32'h600, 1'b0);
    idle(254);
    checks++;
    if (head_age !== 8'd254) begin
      errors++;
      $display("[TB] FAIL age_254: got %0d, required 254", head_age);
    end
    idle(46);
    checks++;
    if (head_age !== 8'd255) begin
      errors++;
      $display("[TB] FAIL age_sat: got %0d, required 255", head_age);
    end
  endtask

  task automatic test_reset_mid_queue();
    do_reset();
    for (int i = 0; i < 7; i++) drive_cycle(1'b1, OP_WRITE, AW'(32'h700 + i), 1'b0);
    rst = 1'b1;
    op_ready_s = 1'b1;
    step();
    rst = 1'b0;
    op_ready_s = 1'b0;
    sb.delete();
    checks++;
    if (occupancy !== 5'd0 || head_valid !== 1'b0 || overflow_err !== 1'b0 || head_address !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset: occ=%0d valid=%b ovf=%b addr=%h, required 0 0 0 0",
               occupancy, head_valid, overflow_err, head_address);
    end
    drive_cycle(1'b1, OP_IFETCH, 32'h800, 1'b0);
    drain("post_reset");
  endtask

  initial begin
    test_reset();
    test_single_push_age();
    test_fill_overflow();
    test_wrap();
    test_back_to_back();
    test_age_saturation();
    test_reset_mid_queue();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
